// File: rtl/axi_rd_resp_model_pkg.sv
// Shared encodings and request-queue entry type for the AXI4 read-slave response model.
package axi_rd_resp_model_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Entry fields are sized for the widest supported address and latency; users narrow them.
    localparam int ADDR_MAX_WDTH = 64;
    localparam int CNT_WDTH      = 16;

    typedef struct packed {
        logic [ADDR_MAX_WDTH-1:0] addr;
        logic [7:0]               len;
        logic                     err;
        logic [CNT_WDTH-1:0]      countdown;
    } rq_entry_t;

    typedef enum logic {
        RD_IDLE,
        RD_BURST
    } rd_state_e;

    function automatic logic [CNT_WDTH-1:0] cnt_dec_sat(input logic [CNT_WDTH-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

endpackage

// File: rtl/axi_rd_req_queue.sv
// Circular FIFO of pending read bursts; every entry carries a saturating latency countdown.
module axi_rd_req_queue
    import axi_rd_resp_model_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  rq_entry_t                    push_entry,
    input  logic                         pop,
    output rq_entry_t                    head_entry,
    output rq_entry_t                    next_entry,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    rq_entry_t        mem_q [DEPTH];
    rq_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // NOTE: start from the held value so every path assigns mem_d and no latch is inferred.
        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i].countdown = cnt_dec_sat(mem_q[i].countdown);
        end
        if (push) begin
            mem_d[wr_ptr_q]           = push_entry;
            mem_d[wr_ptr_q].countdown = CNT_WDTH'(LATENCY);
        end
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // NOTE: non-blocking assignments here so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: storage is reset too, so stale countdowns never make a post-reset entry look eligible.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign next_entry = mem_q[ptr_inc(rd_ptr_q)];
    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;

endmodule

// File: rtl/axi_rd_resp_model.sv
// AXI4 read-slave response model: queued bursts, fixed latency, in-order address-pattern beats.
module axi_rd_resp_model
    import axi_rd_resp_model_pkg::*;
#(
    parameter int AXI_ADDR_WDTH = 32,
    parameter int AXI_DATA_WDTH = 512,
    parameter int OUTSTANDING   = 4,
    parameter int LATENCY       = 8,
    parameter int STALL_MODE    = 0,
    parameter int BUBBLE_PERIOD = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [AXI_ADDR_WDTH-1:0]           ar_addr,
    input  logic [7:0]                         ar_len,
    input  logic [2:0]                         ar_size,
    input  logic [1:0]                         ar_burst,
    input  logic [2:0]                         ar_prot,
    input  logic                               ar_valid,
    output logic                               ar_ready,
    output logic [AXI_DATA_WDTH-1:0]           r_data,
    output logic [1:0]                         r_resp,
    output logic                               r_last,
    output logic                               r_valid,
    input  logic                               r_ready,
    output logic [$clog2(OUTSTANDING+1)-1:0]   outstanding,
    output logic                               model_idle
);

    localparam int         BPB       = AXI_DATA_WDTH / 8;
    localparam logic [2:0] SIZE_FULL = 3'($clog2(BPB));
    localparam int         BUB_W     = $clog2(BUBBLE_PERIOD + 1);
    localparam int         OCW       = $clog2(OUTSTANDING + 1);
    localparam logic [BUB_W-1:0] BUB_MAX = BUB_W'(BUBBLE_PERIOD);

    rq_entry_t push_entry, head_entry, next_entry, src;
    logic      q_full, q_empty, q_push, q_pop;
    logic [OCW-1:0] q_count;
    logic      head_elig, next_elig, load, load_next;
    logic [7:0] load_k;

    rd_state_e              state_q, state_d;
    logic [7:0]             beat_q, beat_d;
    logic [BUB_W-1:0]       bub_q, bub_d;
    logic                   r_valid_q, r_valid_d;
    logic                   r_last_q, r_last_d;
    logic [1:0]             r_resp_q, r_resp_d;
    logic [AXI_DATA_WDTH-1:0] r_data_q, r_data_d;

    function automatic logic [AXI_DATA_WDTH-1:0] beat_pattern(input logic [AXI_ADDR_WDTH-1:0] base,
                                                              input logic [7:0] k);
        logic [AXI_ADDR_WDTH-1:0] beat_addr;
        logic [AXI_ADDR_WDTH-1:0] lane_addr;
        logic [AXI_DATA_WDTH-1:0] d;
        beat_addr = base + AXI_ADDR_WDTH'(k) * AXI_ADDR_WDTH'(BPB);
        for (int i = 0; i < BPB; i++) begin
            lane_addr    = beat_addr + AXI_ADDR_WDTH'(i);
            d[i*8 +: 8]  = lane_addr[7:0];
        end
        return d;
    endfunction

    assign ar_ready   = !q_full;
    assign q_push     = ar_valid && ar_ready;
    assign push_entry = '{addr:      ADDR_MAX_WDTH'(ar_addr),
                          len:       ar_len,
                          err:       (ar_burst != BURST_INCR) || (ar_size != SIZE_FULL),
                          countdown: '0};

    axi_rd_req_queue #(
        .DEPTH   (OUTSTANDING),
        .LATENCY (LATENCY)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (q_push),
        .push_entry (push_entry),
        .pop        (q_pop),
        .head_entry (head_entry),
        .next_entry (next_entry),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_count)
    );

    // A countdown of 1 reaches 0 at this edge, so the first beat is registered on that same edge.
    assign head_elig = !q_empty && (head_entry.countdown <= CNT_WDTH'(1));
    assign next_elig = (q_count > OCW'(1)) && (next_entry.countdown <= CNT_WDTH'(1));

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        bub_d     = bub_q;
        r_valid_d = r_valid_q;
        r_last_d  = r_last_q;
        r_resp_d  = r_resp_q;
        r_data_d  = r_data_q;
        q_pop     = 1'b0;
        load      = 1'b0;
        load_next = 1'b0;
        load_k    = beat_q;
        src       = head_entry;

        case (state_q)
            RD_IDLE: begin
                if (head_elig) begin
                    state_d = RD_BURST;
                    load    = 1'b1;
                    load_k  = '0;
                    bub_d   = '0;
                end
            end
            RD_BURST: begin
                if (!r_valid_q) begin
                    // Bubble cycle is over; present the beat after the one last accepted.
                    load   = 1'b1;
                    load_k = beat_q + 8'd1;
                end else if (r_ready) begin
                    if (r_last_q) begin
                        q_pop = 1'b1;
                        bub_d = '0;
                        if (next_elig) begin
                            load      = 1'b1;
                            load_next = 1'b1;
                            load_k    = '0;
                        end else begin
                            state_d   = RD_IDLE;
                            r_valid_d = 1'b0;
                            r_last_d  = 1'b0;
                        end
                    end else if ((STALL_MODE != 0) && (bub_q + 1'b1 == BUB_MAX)) begin
                        bub_d     = '0;
                        r_valid_d = 1'b0;
                    end else begin
                        bub_d  = bub_q + 1'b1;
                        load   = 1'b1;
                        load_k = beat_q + 8'd1;
                    end
                end
            end
            default: state_d = RD_IDLE;
        endcase

        if (load) begin
            src       = load_next ? next_entry : head_entry;
            r_valid_d = 1'b1;
            beat_d    = load_k;
            r_last_d  = (load_k == src.len);
            r_resp_d  = src.err ? RESP_SLVERR : RESP_OKAY;
            r_data_d  = src.err ? '0 : beat_pattern(src.addr[AXI_ADDR_WDTH-1:0], load_k);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RD_IDLE;
            beat_q    <= '0;
            bub_q     <= '0;
            r_valid_q <= 1'b0;
            r_last_q  <= 1'b0;
            r_resp_q  <= RESP_OKAY;
            r_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            bub_q     <= bub_d;
            r_valid_q <= r_valid_d;
            r_last_q  <= r_last_d;
            r_resp_q  <= r_resp_d;
            r_data_q  <= r_data_d;
        end
    end

    assign r_valid     = r_valid_q;
    assign r_last      = r_last_q;
    assign r_resp      = r_resp_q;
    assign r_data      = r_data_q;
    assign outstanding = q_count;
    assign model_idle  = q_empty && (state_q == RD_IDLE);

    logic unused_ok;
    assign unused_ok = ^{ar_prot, head_entry.addr, next_entry.addr};

endmodule

// File: tb/tb_axi_rd_resp_model.sv
// Randomized scoreboard bench for axi_rd_resp_model with periodic R bubbles enabled.
module tb_axi_rd_resp_model;

    localparam int AW  = 32;
    localparam int DW  = 512;
    localparam int OUT = 4;
    localparam int LAT = 8;
    localparam int BP  = 2;
    localparam int BPB = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        reset;
    logic [AW-1:0]               ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic [2:0]                  ar_prot;
    logic                        ar_valid;
    logic                        ar_ready;
    logic [DW-1:0]               r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic                        r_valid;
    logic                        r_ready;
    logic [$clog2(OUT+1)-1:0]    outstanding;
    logic                        model_idle;

    axi_rd_resp_model #(
        .AXI_ADDR_WDTH (AW),
        .AXI_DATA_WDTH (DW),
        .OUTSTANDING   (OUT),
        .LATENCY       (LAT),
        .STALL_MODE    (1),
        .BUBBLE_PERIOD (BP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ar_addr     (ar_addr),
        .ar_len      (ar_len),
        .ar_size     (ar_size),
        .ar_burst    (ar_burst),
        .ar_prot     (ar_prot),
        .ar_valid    (ar_valid),
        .ar_ready    (ar_ready),
        .r_data      (r_data),
        .r_resp      (r_resp),
        .r_last      (r_last),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .outstanding (outstanding),
        .model_idle  (model_idle)
    );

    // An accepted burst: t is the clock edge (count of edges) at which its AR handshake happened.
    typedef struct {
        logic [31:0] addr;
        int          len;
        bit          err;
        int          t;
    } burst_t;

    burst_t sb[$];
    burst_t cur;
    bit     have_cur = 0;
    int     k        = 0;
    int     hs_cnt   = 0;
    int     earliest = 0;
    int     last_e   = 0;
    int     cyc      = 0;
    int     checks   = 0;
    int     errors   = 0;
    bit     rr_rand  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_beat(input logic [31:0] addr, input int beat);
        logic [DW-1:0] d;
        logic [31:0]   a;
        for (int i = 0; i < BPB; i++) begin
            a           = addr + 32'(beat * BPB + i);
            d[i*8 +: 8] = a[7:0];
        end
        return d;
    endfunction

    // Monitor: at each falling edge compare against the model, then record the handshake
    // that the coming rising edge will perform.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            sb.delete();
            have_cur = 0;
            last_e   = 0;
        end else begin
            int exp_out;
            bit exp_v;
            if (!have_cur && sb.size() > 0 && sb[0].t <= cyc) begin
                cur      = sb.pop_front();
                have_cur = 1;
                k        = 0;
                hs_cnt   = 0;
                earliest = (cur.t + LAT > last_e) ? cur.t + LAT : last_e;
            end
            exp_out = have_cur ? 1 : 0;
            foreach (sb[i]) if (sb[i].t <= cyc) exp_out++;
            exp_v = have_cur && (cyc >= earliest);
            check("r_valid", r_valid, exp_v);
            check("outstanding", outstanding, exp_out);
            check("ar_ready", ar_ready, exp_out < OUT);
            check("model_idle", model_idle, exp_out == 0);
            if (exp_v && r_valid) begin
                check("r_data", r_data, cur.err ? '0 : exp_beat(cur.addr, k));
                check("r_resp", r_resp, cur.err ? 2'b10 : 2'b00);
                check("r_last", r_last, k == cur.len);
                if (r_ready) begin
                    if (k == cur.len) begin
                        last_e   = cyc + 1;
                        have_cur = 0;
                    end else begin
                        k++;
                        hs_cnt++;
                        if (hs_cnt == BP) begin
                            hs_cnt   = 0;
                            earliest = cyc + 2;
                        end else begin
                            earliest = cyc + 1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        r_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            r_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Entered and left 1 time unit after a rising edge, so consecutive calls issue back-to-back.
    task automatic issue_ar(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size);
        bit got = 0;
        ar_addr  = addr;
        ar_len   = len;
        ar_burst = burst;
        ar_size  = size;
        ar_prot  = 3'($urandom_range(0, 7));
        ar_valid = 1'b1;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (ar_ready) begin
                sb.push_back('{addr: addr, len: int'(len),
                               err: (burst != 2'b01) || (size != 3'd6), t: cyc + 1});
                got = 1;
            end
            @(posedge clk);
            #1;
        end
        ar_valid = 1'b0;
        if (!got) check("ar_handshake_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            if (model_idle && sb.size() == 0 && !have_cur) done = 1;
        end
        check("drain", done, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit seen;
        reset    = 1'b1;
        ar_valid = 1'b0;
        ar_addr  = '0;
        ar_len   = '0;
        ar_burst = 2'b01;
        ar_size  = 3'd6;
        ar_prot  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ar_ready", ar_ready, 1);
        check("rst_r_valid", r_valid, 0);
        check("rst_r_last", r_last, 0);
        check("rst_r_resp", r_resp, 0);
        check("rst_r_data", r_data, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_model_idle", model_idle, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single read with the known address pattern.
        issue_ar(32'h0000_1000, 8'd3, 2'b01, 3'd6);
        wait_idle();

        // Five back-to-back requests against a four-deep queue.
        for (int i = 0; i < 5; i++) begin
            issue_ar($urandom, 8'($urandom_range(0, 3)), 2'b01, 3'd6);
        end
        wait_idle();

        // Illegal burst type, then a legal one; also an illegal size.
        issue_ar($urandom, 8'd1, 2'b10, 3'd6);
        issue_ar($urandom, 8'd2, 2'b01, 3'd6);
        issue_ar($urandom, 8'd0, 2'b01, 3'd5);
        wait_idle();

        // Long burst exercising repeated bubbles.
        issue_ar($urandom, 8'd5, 2'b01, 3'd6);
        wait_idle();

        // Random back-pressure, address wrap and a mix of random requests.
        rr_rand = 1;
        issue_ar(32'hFFFF_FFC0, 8'd1, 2'b01, 3'd6);
        for (int i = 0; i < 12; i++) begin
            issue_ar($urandom, 8'($urandom_range(0, 7)),
                     ($urandom_range(0, 7) == 0) ? 2'b00 : 2'b01,
                     ($urandom_range(0, 7) == 0) ? 3'd3 : 3'd6);
        end
        wait_idle();
        rr_rand = 0;

        // Reset in the middle of a burst.
        issue_ar($urandom, 8'd7, 2'b01, 3'd6);
        seen = 0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (r_valid) seen = 1;
        end
        check("burst_start", seen, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_r_valid", r_valid, 0);
        check("midrst_outstanding", outstanding, 0);
        check("midrst_ar_ready", ar_ready, 1);
        @(posedge clk);
        #1;
        issue_ar(32'h0000_2000, 8'd2, 2'b01, 3'd6);
        wait_idle();

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
